// File: rtl/vga_sync_porch_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vga_sync_porch_gen
//
// Purpose:
//   Parametrised porch stage between the sync-pulse generator and the VGA pins.
//   Internal column/row counters lock onto the rising edge of the incoming
//   active-region VSync strobe. HSync/VSync are regenerated from the counters
//   with configurable porches and polarity. Video is delayed by VIDEO_DELAY
//   clocks, kept aligned with its own sync/DE, and blanked outside the active
//   area.
//
// Ports:
//   i_Clk        pixel clock
//   i_Reset      asynchronous active-high reset
//   i_HSync      high while input column < ACTIVE_COLS (level not forwarded)
//   i_VSync      high while input row < ACTIVE_ROWS; rising edge = frame start
//   i_*_Video    input colour channels (VIDEO_WIDTH bits each)
//   o_HSync      regenerated horizontal sync, asserted level SYNC_POL
//   o_VSync      regenerated vertical sync, asserted level SYNC_POL
//   o_DE         high for active pixels, aligned with video outputs
//   o_*_Video    delayed and blanked colour channels
//   o_Locked     counters in phase with the input frame timing
//
// Optional feature (macro VGA_SYNC_LOCK_DET_EN):
//   Defined   - o_Locked tracks two consecutive frame starts landing on the
//               natural counter wrap, with a 2*TOTAL_ROWS*TOTAL_COLS watchdog.
//   Undefined - o_Locked is 1 from the first clock after reset release.
// -----------------------------------------------------------------------------
module vga_sync_porch_gen #(
    parameter int VIDEO_WIDTH   = 3,
    parameter int TOTAL_COLS    = 800,
    parameter int TOTAL_ROWS    = 525,
    parameter int ACTIVE_COLS   = 640,
    parameter int ACTIVE_ROWS   = 480,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_BACK_PORCH  = 33,
    parameter bit SYNC_POL      = 1'b0,
    parameter int VIDEO_DELAY   = 2
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_HSync,
    input  logic                   i_VSync,
    input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic                   o_DE,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
    output logic                   o_Locked
);

    localparam int CW         = $clog2(TOTAL_COLS);
    localparam int RW         = $clog2(TOTAL_ROWS);
    localparam int PW         = 3 * VIDEO_WIDTH;
    // Counters already lag the input by one clock, so the decode path needs
    // one register fewer than the video path to stay aligned.
    localparam int DEC_STAGES = VIDEO_DELAY - 1;

    localparam logic [CW-1:0] COL_LAST = CW'(TOTAL_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(TOTAL_ROWS - 1);
    // One extra bit so ACTIVE == 2**width still compares correctly.
    localparam logic [CW:0]   COL_ACT  = (CW+1)'(ACTIVE_COLS);
    localparam logic [CW:0]   HP_START = (CW+1)'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [CW:0]   HP_END   = (CW+1)'(TOTAL_COLS - H_BACK_PORCH - 1);
    localparam logic [RW:0]   ROW_ACT  = (RW+1)'(ACTIVE_ROWS);
    localparam logic [RW:0]   VP_START = (RW+1)'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [RW:0]   VP_END   = (RW+1)'(TOTAL_ROWS - V_BACK_PORCH - 1);

    if ((ACTIVE_COLS + H_FRONT_PORCH + H_BACK_PORCH > TOTAL_COLS) ||
        (ACTIVE_ROWS + V_FRONT_PORCH + V_BACK_PORCH > TOTAL_ROWS)) begin : g_bad_geometry
        $error("vga_sync_porch_gen: active area plus porches exceeds total timing");
    end
    if ((VIDEO_DELAY < 2) || (VIDEO_DELAY > 8)) begin : g_bad_delay
        $error("vga_sync_porch_gen: VIDEO_DELAY must be within 2..8");
    end

    // Input HSync level carries no information beyond what the counters give.
    logic unused_hsync;
    assign unused_hsync = i_HSync;

    logic          vsync_prev_q;
    logic          frame_start;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          hpulse, vpulse, de_now;

    logic [PW-1:0] vid_q [VIDEO_DELAY];
    logic [2:0]    dec_q [DEC_STAGES];   // {hpulse, vpulse, de}
    logic [2:0]    dec_out;
    logic          locked_q;

    always_comb begin
        frame_start = i_VSync & ~vsync_prev_q;
        col_d       = col_q;
        row_d       = row_q;
        if (frame_start) begin
            col_d = '0;
            row_d = '0;
        end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end else begin
            col_d = col_q + CW'(1);
        end
    end

    always_comb begin
        hpulse = ({1'b0, col_q} >= HP_START) && ({1'b0, col_q} <= HP_END);
        vpulse = ({1'b0, row_q} >= VP_START) && ({1'b0, row_q} <= VP_END);
        de_now = ({1'b0, col_q} < COL_ACT) && ({1'b0, row_q} < ROW_ACT);
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            vsync_prev_q <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            for (int unsigned i = 0; i < VIDEO_DELAY; i++) vid_q[i] <= '0;
            for (int unsigned i = 0; i < DEC_STAGES; i++)  dec_q[i] <= '0;
        end else begin
            vsync_prev_q <= i_VSync;
            col_q        <= col_d;
            row_q        <= row_d;
            vid_q[0]     <= {i_Red_Video, i_Grn_Video, i_Blu_Video};
            for (int unsigned i = 1; i < VIDEO_DELAY; i++) vid_q[i] <= vid_q[i-1];
            dec_q[0]     <= {hpulse, vpulse, de_now};
            for (int unsigned i = 1; i < DEC_STAGES; i++)  dec_q[i] <= dec_q[i-1];
        end
    end

    assign dec_out = dec_q[DEC_STAGES-1];
    assign o_HSync = dec_out[2] ? SYNC_POL : ~SYNC_POL;
    assign o_VSync = dec_out[1] ? SYNC_POL : ~SYNC_POL;
    assign o_DE    = dec_out[0];
    assign {o_Red_Video, o_Grn_Video, o_Blu_Video} = dec_out[0] ? vid_q[VIDEO_DELAY-1] : '0;

`ifdef VGA_SYNC_LOCK_DET_EN
    localparam int             WD_LIMIT = 2 * TOTAL_ROWS * TOTAL_COLS;
    localparam int             WDW      = $clog2(WD_LIMIT + 1);
    localparam logic [WDW-1:0] WD_MAX   = WDW'(WD_LIMIT);

    logic [WDW-1:0] wd_q, wd_d;
    logic           prev_match_q, prev_match_d;
    logic           locked_d;
    logic           at_wrap;

    always_comb begin
        at_wrap      = (col_q == COL_LAST) && (row_q == ROW_LAST);
        wd_d         = wd_q;
        prev_match_d = prev_match_q;
        locked_d     = locked_q;
        if (frame_start) begin
            wd_d = '0;
            if (at_wrap) begin
                // Second consecutive frame start on the natural wrap locks.
                if (prev_match_q) locked_d = 1'b1;
                prev_match_d = 1'b1;
            end else begin
                prev_match_d = 1'b0;
                locked_d     = 1'b0;
            end
        end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + WDW'(1);
            if (wd_d == WD_MAX) begin
                prev_match_d = 1'b0;
                locked_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            wd_q         <= '0;
            prev_match_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            wd_q         <= wd_d;
            prev_match_q <= prev_match_d;
            locked_q     <= locked_d;
        end
    end
`else
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) locked_q <= 1'b0;
        else         locked_q <= 1'b1;
    end
`endif

    assign o_Locked = locked_q;

endmodule

// File: tb/tb_vga_sync_porch_gen.sv
`timescale 1ns/1ps
module tb_vga_sync_porch_gen;

`ifdef VGA_SYNC_LOCK_DET_EN
    localparam bit LOCK_DET = 1'b1;
`else
    localparam bit LOCK_DET = 1'b0;
`endif

    // Reduced geometry: hsync pulse cols 14..16, vsync pulse rows 7..8.
    localparam int VW = 3, TC = 20, TR = 10, AC = 12, AR = 6;
    localparam int HFP = 2, HBP = 3, VFP = 1, VBP = 1;
    localparam int D1 = 2, D2 = 5;

    logic i_Clk = 1'b0;
    logic i_Reset = 1'b1;
    logic i_HSync = 1'b0, i_VSync = 1'b0;
    logic [VW-1:0] i_Red_Video = '0, i_Grn_Video = '0, i_Blu_Video = '0;
    logic h1, v1, de1, lk1, h2, v2, de2, lk2;
    logic [VW-1:0] r1, g1, b1, r2, g2, b2;

    always #5 i_Clk = ~i_Clk;

    vga_sync_porch_gen #(
        .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
        .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .H_FRONT_PORCH(HFP), .H_BACK_PORCH(HBP),
        .V_FRONT_PORCH(VFP), .V_BACK_PORCH(VBP),
        .SYNC_POL(1'b0), .VIDEO_DELAY(D1)
    ) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_HSync(i_HSync), .i_VSync(i_VSync),
        .i_Red_Video(i_Red_Video), .i_Grn_Video(i_Grn_Video), .i_Blu_Video(i_Blu_Video),
        .o_HSync(h1), .o_VSync(v1), .o_DE(de1),
        .o_Red_Video(r1), .o_Grn_Video(g1), .o_Blu_Video(b1), .o_Locked(lk1)
    );

    vga_sync_porch_gen #(
        .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
        .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .H_FRONT_PORCH(HFP), .H_BACK_PORCH(HBP),
        .V_FRONT_PORCH(VFP), .V_BACK_PORCH(VBP),
        .SYNC_POL(1'b1), .VIDEO_DELAY(D2)
    ) dut2 (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_HSync(i_HSync), .i_VSync(i_VSync),
        .i_Red_Video(i_Red_Video), .i_Grn_Video(i_Grn_Video), .i_Blu_Video(i_Blu_Video),
        .o_HSync(h2), .o_VSync(v2), .o_DE(de2),
        .o_Red_Video(r2), .o_Grn_Video(g2), .o_Blu_Video(b2), .o_Locked(lk2)
    );

    int n_cmp = 0, n_bad = 0;
    int g_col = 0, g_row = 0, hp = 0;
    bit syncs_off = 1'b0;
    int hc [8], hr [8];
    logic [3*VW-1:0] hv [8];

    function automatic logic e_de(input int c, input int r);
        return (c < AC) && (r < AR);
    endfunction
    function automatic logic e_hp(input int c);
        return (c >= AC + HFP) && (c <= TC - HBP - 1);
    endfunction
    function automatic logic e_vp(input int r);
        return (r >= AR + VFP) && (r <= TR - VBP - 1);
    endfunction

    // Present one pixel of the input raster, clock it, then sample point.
    task automatic drive(input logic [VW-1:0] r, input logic [VW-1:0] g, input logic [VW-1:0] b);
        i_HSync     = !syncs_off && (g_col < AC);
        i_VSync     = !syncs_off && (g_row < AR);
        i_Red_Video = r;
        i_Grn_Video = g;
        i_Blu_Video = b;
        hc[hp] = g_col;
        hr[hp] = g_row;
        hv[hp] = {r, g, b};
        hp = (hp + 1) % 8;
        @(posedge i_Clk);
        #1;
        if (g_col == TC - 1) begin
            g_col = 0;
            g_row = (g_row == TR - 1) ? 0 : g_row + 1;
        end else begin
            g_col++;
        end
    endtask

    task automatic drive_pat();
        drive(VW'(g_col + g_row), VW'(g_col), VW'(g_row + 1));
    endtask

    task automatic run_to(input int c, input int r);
        for (int i = 0; i <= TC * TR && !(g_col == c && g_row == r); i++) drive('0, '0, '0);
        n_cmp++;
        if (!(g_col == c && g_row == r)) begin
            n_bad++;
            $display("FAIL run_to: reached col %0d row %0d, required col %0d row %0d", g_col, g_row, c, r);
        end
    endtask

    task automatic test_reset();
        i_Reset = 1'b1;
        repeat (3) @(posedge i_Clk);
        #1;
        n_cmp++; if (h1 !== 1'b1)  begin n_bad++; $display("FAIL rst_hsync1: got %b want 1", h1); end
        n_cmp++; if (v1 !== 1'b1)  begin n_bad++; $display("FAIL rst_vsync1: got %b want 1", v1); end
        n_cmp++; if (de1 !== 1'b0) begin n_bad++; $display("FAIL rst_de1: got %b want 0", de1); end
        n_cmp++; if ({r1, g1, b1} !== '0) begin n_bad++; $display("FAIL rst_video1: got %h want 0", {r1, g1, b1}); end
        n_cmp++; if (lk1 !== 1'b0) begin n_bad++; $display("FAIL rst_locked1: got %b want 0", lk1); end
        n_cmp++; if (h2 !== 1'b0)  begin n_bad++; $display("FAIL rst_hsync2: got %b want 0", h2); end
        n_cmp++; if (v2 !== 1'b0)  begin n_bad++; $display("FAIL rst_vsync2: got %b want 0", v2); end
        n_cmp++; if (de2 !== 1'b0) begin n_bad++; $display("FAIL rst_de2: got %b want 0", de2); end
        i_Reset = 1'b0;
        g_col = 0;
        g_row = 0;
        drive('0, '0, '0);
        n_cmp++;
        if (lk1 !== !LOCK_DET) begin n_bad++; $display("FAIL rel_locked1: got %b want %b", lk1, !LOCK_DET); end
    endtask

    // Caller guarantees a frame start at or before the first flush step.
    task automatic test_frame_timing(input string tag);
        int n_de = 0, n_hl = 0, n_vl = 0, n_h2 = 0;
        int i1, i2;
        logic eh, ev, ed;
        logic [3*VW-1:0] evid;
        repeat (5) drive_pat();
        for (int s = 0; s < TC * TR; s++) begin
            drive_pat();
            i1 = (hp - D1 + 8) % 8;
            i2 = (hp - D2 + 8) % 8;
            eh = !e_hp(hc[i1]); ev = !e_vp(hr[i1]); ed = e_de(hc[i1], hr[i1]);
            evid = ed ? hv[i1] : '0;
            n_cmp++; if (h1 !== eh)  begin n_bad++; $display("FAIL %s hsync1 c%0d r%0d: got %b want %b", tag, hc[i1], hr[i1], h1, eh); end
            n_cmp++; if (v1 !== ev)  begin n_bad++; $display("FAIL %s vsync1 c%0d r%0d: got %b want %b", tag, hc[i1], hr[i1], v1, ev); end
            n_cmp++; if (de1 !== ed) begin n_bad++; $display("FAIL %s de1 c%0d r%0d: got %b want %b", tag, hc[i1], hr[i1], de1, ed); end
            n_cmp++; if ({r1, g1, b1} !== evid) begin n_bad++; $display("FAIL %s video1 c%0d r%0d: got %h want %h", tag, hc[i1], hr[i1], {r1, g1, b1}, evid); end
            eh = e_hp(hc[i2]); ev = e_vp(hr[i2]); ed = e_de(hc[i2], hr[i2]);
            evid = ed ? hv[i2] : '0;
            n_cmp++; if (h2 !== eh)  begin n_bad++; $display("FAIL %s hsync2 c%0d r%0d: got %b want %b", tag, hc[i2], hr[i2], h2, eh); end
            n_cmp++; if (v2 !== ev)  begin n_bad++; $display("FAIL %s vsync2 c%0d r%0d: got %b want %b", tag, hc[i2], hr[i2], v2, ev); end
            n_cmp++; if (de2 !== ed) begin n_bad++; $display("FAIL %s de2 c%0d r%0d: got %b want %b", tag, hc[i2], hr[i2], de2, ed); end
            n_cmp++; if ({r2, g2, b2} !== evid) begin n_bad++; $display("FAIL %s video2 c%0d r%0d: got %h want %h", tag, hc[i2], hr[i2], {r2, g2, b2}, evid); end
            if (de1) n_de++;
            if (!h1) n_hl++;
            if (!v1) n_vl++;
            if (h2)  n_h2++;
        end
        n_cmp++; if (n_de != 72) begin n_bad++; $display("FAIL %s de_count: got %0d want 72", tag, n_de); end
        n_cmp++; if (n_hl != 30) begin n_bad++; $display("FAIL %s hsync_low_count: got %0d want 30", tag, n_hl); end
        n_cmp++; if (n_vl != 40) begin n_bad++; $display("FAIL %s vsync_low_count: got %0d want 40", tag, n_vl); end
        n_cmp++; if (n_h2 != 30) begin n_bad++; $display("FAIL %s hsync2_high_count: got %0d want 30", tag, n_h2); end
    endtask

    task automatic test_delay_pol();
        logic [VW-1:0] e1, e2;
        run_to(10, 2);
        for (int j = 1; j <= 6; j++) begin
            if (j == 1) drive(3'b101, '0, '0);
            else        drive('0, '0, '0);
            e1 = (j == 2) ? 3'b101 : 3'b000;
            e2 = (j == 5) ? 3'b101 : 3'b000;
            n_cmp++; if (r1 !== e1) begin n_bad++; $display("FAIL delay_red1 step %0d: got %b want %b", j, r1, e1); end
            n_cmp++; if (r2 !== e2) begin n_bad++; $display("FAIL delay_red2 step %0d: got %b want %b", j, r2, e2); end
            if (j == 5) begin
                n_cmp++; if (de2 !== 1'b1) begin n_bad++; $display("FAIL delay_de2: got %b want 1", de2); end
                n_cmp++; if (h2 !== 1'b0)  begin n_bad++; $display("FAIL delay_hsync2: got %b want 0", h2); end
            end
        end
    endtask

    task automatic test_blanking();
        logic [3*VW-1:0] e;
        run_to(11, 3);
        for (int j = 1; j <= 9; j++) begin
            drive('1, '1, '1);
            if (j >= 2) begin
                e = (j == 2) ? '1 : '0;
                n_cmp++; if ({r1, g1, b1} !== e) begin n_bad++; $display("FAIL blank_video1 col %0d: got %h want %h", 9 + j, {r1, g1, b1}, e); end
                n_cmp++; if (de1 !== (j == 2)) begin n_bad++; $display("FAIL blank_de1 col %0d: got %b want %b", 9 + j, de1, j == 2); end
            end
            if (j >= 5) begin
                e = (j == 5) ? '1 : '0;
                n_cmp++; if ({r2, g2, b2} !== e) begin n_bad++; $display("FAIL blank_video2 col %0d: got %h want %h", 6 + j, {r2, g2, b2}, e); end
            end
        end
    endtask

    task automatic test_jump();
        run_to(1, 0);
        n_cmp++; if (lk1 !== 1'b1) begin n_bad++; $display("FAIL jump_prelock1: got %b want 1", lk1); end
        run_to(7, 3);
        g_col = TC - 1;
        g_row = TR - 1;
        drive_pat();
        drive_pat();
        n_cmp++; if (lk1 !== !LOCK_DET) begin n_bad++; $display("FAIL jump_lock_drop1: got %b want %b", lk1, !LOCK_DET); end
        n_cmp++; if (lk2 !== !LOCK_DET) begin n_bad++; $display("FAIL jump_lock_drop2: got %b want %b", lk2, !LOCK_DET); end
        test_frame_timing("jump");
        n_cmp++; if (lk1 !== !LOCK_DET) begin n_bad++; $display("FAIL jump_lock_one_frame: got %b want %b", lk1, !LOCK_DET); end
        run_to(1, 0);
        n_cmp++; if (lk1 !== 1'b1) begin n_bad++; $display("FAIL jump_relock1: got %b want 1", lk1); end
        n_cmp++; if (lk2 !== 1'b1) begin n_bad++; $display("FAIL jump_relock2: got %b want 1", lk2); end
    endtask

    // Entered one step after a frame start; watchdog limit is 2*TC*TR = 400.
    task automatic test_stop_syncs();
        syncs_off = 1'b1;
        test_frame_timing("freerun");
        n_cmp++; if (lk1 !== 1'b1) begin n_bad++; $display("FAIL stop_lock_205: got %b want 1", lk1); end
        repeat (190) drive_pat();
        n_cmp++; if (lk1 !== 1'b1) begin n_bad++; $display("FAIL stop_lock_395: got %b want 1", lk1); end
        repeat (10) drive_pat();
        n_cmp++; if (lk1 !== !LOCK_DET) begin n_bad++; $display("FAIL stop_lock_405: got %b want %b", lk1, !LOCK_DET); end
        n_cmp++; if (lk2 !== !LOCK_DET) begin n_bad++; $display("FAIL stop_lock2_405: got %b want %b", lk2, !LOCK_DET); end
        run_to(0, 7);
        syncs_off = 1'b0;
    endtask

    task automatic test_reset_mid();
        run_to(8, 7);
        n_cmp++; if (v1 !== 1'b0) begin n_bad++; $display("FAIL pre_reset_vsync1: got %b want 0", v1); end
        i_Reset = 1'b1;
        #1;
        n_cmp++; if (h1 !== 1'b1)  begin n_bad++; $display("FAIL mid_rst_hsync1: got %b want 1", h1); end
        n_cmp++; if (v1 !== 1'b1)  begin n_bad++; $display("FAIL mid_rst_vsync1: got %b want 1", v1); end
        n_cmp++; if (de1 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_de1: got %b want 0", de1); end
        n_cmp++; if ({r1, g1, b1} !== '0) begin n_bad++; $display("FAIL mid_rst_video1: got %h want 0", {r1, g1, b1}); end
        n_cmp++; if (lk1 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_locked1: got %b want 0", lk1); end
        n_cmp++; if (v2 !== 1'b0)  begin n_bad++; $display("FAIL mid_rst_vsync2: got %b want 0", v2); end
        repeat (3) drive_pat();
        n_cmp++; if (de1 !== 1'b0) begin n_bad++; $display("FAIL held_rst_de1: got %b want 0", de1); end
        n_cmp++; if (h1 !== 1'b1)  begin n_bad++; $display("FAIL held_rst_hsync1: got %b want 1", h1); end
        i_Reset = 1'b0;
        drive_pat();
        n_cmp++; if (lk1 !== !LOCK_DET) begin n_bad++; $display("FAIL mid_rel_locked1: got %b want %b", lk1, !LOCK_DET); end
        run_to(0, 0);
        test_frame_timing("after_reset");
    endtask

    initial begin
        test_reset();
        test_frame_timing("first_frame");
        test_delay_pol();
        test_blanking();
        test_jump();
        test_stop_syncs();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
